// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Responder side of the memory-stage load/store interface. Takes one request
//   at a time over valid/ready, waits LATENCY cycles, then performs a
//   byte/half/word store or a sign/zero-extended load on an internal
//   little-endian byte array and returns a one-cycle response pulse.
//
// Ports
//   clk             clock, all state updates on the rising edge
//   rst             asynchronous active-low reset
//   req_valid_i     request present
//   req_ready_o     high only in IDLE
//   req_we_i        1 = store, 0 = load
//   req_size_i      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned_i  loads: 1 = zero-extend, 0 = sign-extend
//   req_addr_i      byte address (bits above ADDRESS_WIDTH-1 ignored)
//   req_wdata_i     store data, low 8/16/32 bits used per size
//   rsp_valid_o     one-cycle response pulse
//   rsp_rdata_o     extended load data, 0 for stores and errors
//   rsp_err_o       misaligned or illegal-size request
//   busy_o          high whenever the responder is not IDLE
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | wait-state down-counter running
// RESP  | response pulse; array access was done on the entering edge

module data_mem_responder #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int LATENCY       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  busy_o
);

  localparam int NUM_BYTES = 2 ** ADDRESS_WIDTH;
  localparam int LANES     = DATA_WIDTH / 8;
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       commit;

  // request fields captured at acceptance
  logic                     we_q;
  logic [1:0]               size_q;
  logic                     uns_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;

  // operation fields seen by the array access: with LATENCY=0 the access
  // happens on the accepting edge itself, so the live inputs must be used
  logic                     op_we;
  logic [1:0]               op_size;
  logic                     op_uns;
  logic [ADDRESS_WIDTH-1:0] op_addr;
  logic [DATA_WIDTH-1:0]    op_wdata;
  logic                     op_err;

  logic [7:0]            mem [NUM_BYTES];
  logic [7:0]            rd_lane [LANES];
  logic [DATA_WIDTH-1:0] word_raw;
  logic [DATA_WIDTH-1:0] load_data;
  logic [LANES-1:0]      byte_en;
  logic                  ext_b;
  logic                  ext_h;
  logic                  accept;

  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr_i[DATA_WIDTH-1:ADDRESS_WIDTH];

  assign req_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign accept      = req_valid_i && (state_q == ST_IDLE);

  always_comb begin
    if (state_q == ST_IDLE) begin
      op_we    = req_we_i;
      op_size  = req_size_i;
      op_uns   = req_unsigned_i;
      op_addr  = req_addr_i[ADDRESS_WIDTH-1:0];
      op_wdata = req_wdata_i;
    end else begin
      op_we    = we_q;
      op_size  = size_q;
      op_uns   = uns_q;
      op_addr  = addr_q;
      op_wdata = wdata_q;
    end
  end

  always_comb begin
    op_err = 1'b0;
    case (op_size)
      2'b00:   op_err = 1'b0;
      2'b01:   op_err = op_addr[0];
      2'b10:   op_err = (op_addr[1:0] != 2'b00);
      default: op_err = 1'b1;
    endcase
  end

  always_comb begin
    byte_en = '0;
    case (op_size)
      2'b00:   byte_en = LANES'(1);
      2'b01:   byte_en = LANES'(3);
      2'b10:   byte_en = '1;
      default: byte_en = '0;
    endcase
  end

  // next-state and wait-state counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          if (LATENCY == 0) begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we_i;
      size_q  <= req_size_i;
      uns_q   <= req_unsigned_i;
      addr_q  <= req_addr_i[ADDRESS_WIDTH-1:0];
      wdata_q <= req_wdata_i;
    end
  end

  // little-endian read lanes starting at the operation address
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      rd_lane[i] = mem[op_addr + ADDRESS_WIDTH'(i)];
    end
  end

  always_comb begin
    word_raw = '0;
    for (int i = 0; i < LANES; i++) begin
      word_raw[8*i +: 8] = rd_lane[i];
    end
  end

  assign ext_b = ~op_uns & rd_lane[0][7];
  assign ext_h = ~op_uns & rd_lane[1][7];

  always_comb begin
    load_data = '0;
    case (op_size)
      2'b00:   load_data = {{(DATA_WIDTH-8){ext_b}}, rd_lane[0]};
      2'b01:   load_data = {{(DATA_WIDTH-16){ext_h}}, rd_lane[1], rd_lane[0]};
      2'b10:   load_data = word_raw;
      default: load_data = '0;
    endcase
  end

  // array contents survive reset; only a committed, error-free store writes
  always_ff @(posedge clk) begin
    if (commit && op_we && !op_err) begin
      for (int i = 0; i < LANES; i++) begin
        if (byte_en[i]) begin
          mem[op_addr + ADDRESS_WIDTH'(i)] <= op_wdata[8*i +: 8];
        end
      end
    end
  end

  // response data holds until the next commit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else if (commit) begin
      rsp_err_o   <= op_err;
      rsp_rdata_o <= (op_err || op_we) ? '0 : load_data;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        v2, v0;
  logic        req_we, req_uns;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic        rdy2, rv2, err2, busy2;
  logic [31:0] rd2;
  logic        rdy0, rv0, err0, busy0;
  logic [31:0] rd0;

  int n_vec = 0;
  int n_err = 0;

  // byte-array reference, one per instance (index 0: LATENCY=2, 1: LATENCY=0)
  logic [7:0] ref_mem [0:1][0:255];

  data_mem_responder #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32), .LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .req_valid_i(v2), .req_ready_o(rdy2), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_uns),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rv2), .rsp_rdata_o(rd2), .rsp_err_o(err2), .busy_o(busy2)
  );

  data_mem_responder #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid_i(v0), .req_ready_o(rdy0), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_uns),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rv0), .rsp_rdata_o(rd0), .rsp_err_o(err0), .busy_o(busy0)
  );

  function automatic logic o_rdy(bit s);   return s ? rdy0 : rdy2;   endfunction
  function automatic logic o_rv(bit s);    return s ? rv0 : rv2;     endfunction
  function automatic logic o_err(bit s);   return s ? err0 : err2;   endfunction
  function automatic logic o_busy(bit s);  return s ? busy0 : busy2; endfunction
  function automatic logic [31:0] o_rd(bit s); return s ? rd0 : rd2; endfunction
  function automatic int lat_of(bit s);    return s ? 0 : 2;         endfunction

  task automatic set_valid(input bit s, input logic v);
    if (s) v0 = v; else v2 = v;
  endtask

  function automatic bit m_err(logic [1:0] sz, logic [7:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] m_load(int s, logic [1:0] sz, logic uns, logic [7:0] a);
    logic [31:0] v;
    v = 32'd0;
    if (m_err(sz, a)) return 32'd0;
    for (int i = 0; i < (1 << sz); i++) v = v | (32'(ref_mem[s][8'(a + i)]) << (8 * i));
    if (sz == 2'd0 && !uns && v[7])  v = v | 32'hFFFF_FF00;
    if (sz == 2'd1 && !uns && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic m_store(input int s, input logic [1:0] sz, input logic [7:0] a, input logic [31:0] wd);
    if (m_err(sz, a)) return;
    for (int i = 0; i < (1 << sz); i++) ref_mem[s][8'(a + i)] = wd[8*i +: 8];
  endtask

  // Issues one request (caller is #1 after a rising edge, DUT idle), returns
  // the response fields and the number of edges from acceptance to the pulse
  // (-1 if none arrives within the budget). Ends #1 after the edge leaving RESP.
  task automatic do_txn(input bit s, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    req_we = we; req_size = sz; req_uns = uns; req_addr = addr; req_wdata = wd;
    set_valid(s, 1'b1);
    @(posedge clk); #1;
    set_valid(s, 1'b0);
    req_we = 1'($urandom); req_size = 2'($urandom); req_uns = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 0;
    while (!o_rv(s) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 20) lat = -1;
    rd = o_rd(s);
    er = o_err(s);
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    for (int s = 0; s < 2; s++) begin
      n_vec++; if (o_rdy(s) !== 1'b1)  begin n_err++; $display("FAIL reset_ready dut%0d got=%b exp=1", s, o_rdy(s)); end
      n_vec++; if (o_busy(s) !== 1'b0) begin n_err++; $display("FAIL reset_busy dut%0d got=%b exp=0", s, o_busy(s)); end
      n_vec++; if (o_rv(s) !== 1'b0)   begin n_err++; $display("FAIL reset_valid dut%0d got=%b exp=0", s, o_rv(s)); end
      n_vec++; if (o_rd(s) !== 32'd0)  begin n_err++; $display("FAIL reset_rdata dut%0d got=%h exp=0", s, o_rd(s)); end
      n_vec++; if (o_err(s) !== 1'b0)  begin n_err++; $display("FAIL reset_err dut%0d got=%b exp=0", s, o_err(s)); end
    end
  endtask

  task automatic test_fill;
    logic [31:0] rd, w;
    logic er;
    int lat;
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 256; a += 4) begin
        w = $urandom;
        do_txn(s[0], 1'b1, 2'd2, 1'b0, 32'(a), w, rd, er, lat);
        m_store(s, 2'd2, 8'(a), w);
        n_vec++; if (er !== 1'b0 || rd !== 32'd0) begin n_err++; $display("FAIL fill_rsp dut%0d a=%h got err=%b rd=%h exp err=0 rd=0", s, a, er, rd); end
        n_vec++; if (lat !== lat_of(s[0])) begin n_err++; $display("FAIL fill_latency dut%0d got=%0d exp=%0d", s, lat, lat_of(s[0])); end
      end
    end
  endtask

  task automatic test_reset_abort;
    logic [31:0] rd;
    logic er;
    int lat;
    req_we = 1'b1; req_size = 2'd2; req_uns = 1'b0; req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF;
    v2 = 1'b1;
    @(posedge clk); #1;
    v2 = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    n_vec++; if (rdy2 !== 1'b1)   begin n_err++; $display("FAIL abort_ready got=%b exp=1", rdy2); end
    n_vec++; if (busy2 !== 1'b0)  begin n_err++; $display("FAIL abort_busy got=%b exp=0", busy2); end
    n_vec++; if (rv2 !== 1'b0)    begin n_err++; $display("FAIL abort_valid got=%b exp=0", rv2); end
    n_vec++; if (rd2 !== 32'd0)   begin n_err++; $display("FAIL abort_rdata got=%h exp=0", rd2); end
    n_vec++; if (err2 !== 1'b0)   begin n_err++; $display("FAIL abort_err got=%b exp=0", err2); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (rv2 !== 1'b0 || rdy2 !== 1'b1 || busy2 !== 1'b0) begin
        n_err++; $display("FAIL abort_post_release cyc%0d got valid=%b ready=%b busy=%b exp 0/1/0", i, rv2, rdy2, busy2);
      end
      @(posedge clk); #1;
    end
    do_txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, rd, er, lat);
    n_vec++; if (rd !== m_load(0, 2'd2, 1'b0, 8'h20) || er !== 1'b0) begin
      n_err++; $display("FAIL abort_discarded got=%h err=%b exp=%h err=0", rd, er, m_load(0, 2'd2, 1'b0, 8'h20));
    end
  endtask

  task automatic test_store_timing;
    logic [31:0] rd;
    logic er;
    int lat, cyc, pulses, pulse_at;
    logic [7:0]  la [5] = '{8'h10, 8'h13, 8'h13, 8'h12, 8'h10};
    logic [1:0]  ls [5] = '{2'd2, 2'd0, 2'd0, 2'd1, 2'd1};
    logic        lu [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] le [5] = '{32'h8BAD_F00D, 32'hFFFF_FF8B, 32'h0000_008B, 32'h0000_8BAD, 32'hFFFF_F00D};
    req_we = 1'b1; req_size = 2'd2; req_uns = 1'b0; req_addr = 32'h10; req_wdata = 32'h8BAD_F00D;
    v2 = 1'b1;
    @(posedge clk); #1;
    v2 = 1'b0; req_wdata = $urandom; req_addr = $urandom;
    cyc = 0; pulses = 0; pulse_at = -1;
    while (!rdy2 && cyc < 20) begin
      if (rv2) begin
        pulses++; pulse_at = cyc;
        n_vec++; if (err2 !== 1'b0 || rd2 !== 32'd0) begin n_err++; $display("FAIL store_rsp got err=%b rd=%h exp err=0 rd=0", err2, rd2); end
      end
      n_vec++; if (busy2 !== 1'b1) begin n_err++; $display("FAIL store_busy cyc%0d got=%b exp=1", cyc, busy2); end
      @(posedge clk); #1;
      cyc++;
    end
    m_store(0, 2'd2, 8'h10, 32'h8BAD_F00D);
    n_vec++; if (cyc !== 3) begin n_err++; $display("FAIL store_ready_low got=%0d exp=3", cyc); end
    n_vec++; if (pulses !== 1 || pulse_at !== 2) begin n_err++; $display("FAIL store_pulse got count=%0d at=%0d exp count=1 at=2", pulses, pulse_at); end
    for (int i = 0; i < 5; i++) begin
      do_txn(1'b0, 1'b0, ls[i], lu[i], 32'(la[i]), 32'd0, rd, er, lat);
      n_vec++; if (rd !== le[i] || er !== 1'b0) begin n_err++; $display("FAIL load_ext%0d got=%h err=%b exp=%h err=0", i, rd, er, le[i]); end
    end
    do_txn(1'b0, 1'b1, 2'd0, 1'b0, 32'h11, 32'hAAAA_AA55, rd, er, lat);
    m_store(0, 2'd0, 8'h11, 32'hAAAA_AA55);
    do_txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd, er, lat);
    n_vec++; if (rd !== 32'h8BAD_550D) begin n_err++; $display("FAIL byte_lane got=%h exp=8bad550d", rd); end
  endtask

  task automatic test_errors;
    logic [31:0] rd, before0;
    logic er;
    int lat;
    logic        ew [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [1:0]  es [4] = '{2'd2, 2'd1, 2'd3, 2'd3};
    logic [31:0] ea [4] = '{32'h12, 32'h13, 32'h00, 32'h04};
    before0 = m_load(0, 2'd2, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      do_txn(1'b0, ew[i], es[i], 1'b0, ea[i], $urandom, rd, er, lat);
      n_vec++; if (er !== 1'b1 || rd !== 32'd0) begin n_err++; $display("FAIL err_rsp%0d got err=%b rd=%h exp err=1 rd=0", i, er, rd); end
      n_vec++; if (lat !== 2) begin n_err++; $display("FAIL err_latency%0d got=%0d exp=2", i, lat); end
    end
    do_txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd, er, lat);
    n_vec++; if (rd !== 32'h8BAD_550D) begin n_err++; $display("FAIL err_nowrite10 got=%h exp=8bad550d", rd); end
    do_txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h00, 32'd0, rd, er, lat);
    n_vec++; if (rd !== before0) begin n_err++; $display("FAIL err_nowrite00 got=%h exp=%h", rd, before0); end
  endtask

  task automatic test_random;
    logic [31:0] rd, addr, wd, exp_rd;
    logic er, we, uns, exp_er;
    logic [1:0] sz;
    bit s;
    int lat;
    for (int n = 0; n < 300; n++) begin
      s = 1'($urandom); we = 1'($urandom); uns = 1'($urandom);
      sz = 2'($urandom_range(0, 3));
      addr = $urandom; wd = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) addr[0] = 1'b0;
        if (sz == 2'd2) addr[1:0] = 2'b00;
      end
      exp_er = m_err(sz, addr[7:0]);
      exp_rd = (we || exp_er) ? 32'd0 : m_load(s, sz, uns, addr[7:0]);
      do_txn(s, we, sz, uns, addr, wd, rd, er, lat);
      if (we) m_store(s, sz, addr[7:0], wd);
      n_vec++; if (rd !== exp_rd) begin n_err++; $display("FAIL rand_rdata dut%0d we=%b sz=%0d a=%h got=%h exp=%h", s, we, sz, addr, rd, exp_rd); end
      n_vec++; if (er !== exp_er) begin n_err++; $display("FAIL rand_err dut%0d sz=%0d a=%h got=%b exp=%b", s, sz, addr, er, exp_er); end
      n_vec++; if (lat !== lat_of(s)) begin n_err++; $display("FAIL rand_latency dut%0d got=%0d exp=%0d", s, lat, lat_of(s)); end
    end
  endtask

  task automatic test_back_to_back(input bit s);
    logic [7:0]  ba [3] = '{8'h40, 8'h44, 8'h4A};
    logic [1:0]  bs [3] = '{2'd2, 2'd2, 2'd1};
    logic        bu [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] bexp [3];
    int acc [$];
    int rcyc [$];
    logic [31:0] rdat [$];
    int cyc, k, le;
    bit rb;
    le = lat_of(s);
    cyc = 0; k = 0;
    for (int i = 0; i < 3; i++) bexp[i] = m_load(s, bs[i], bu[i], ba[i]);
    req_we = 1'b0; req_size = bs[0]; req_uns = bu[0]; req_addr = 32'(ba[0]); req_wdata = $urandom;
    set_valid(s, 1'b1);
    while (rcyc.size() < 3 && cyc < 60) begin
      rb = o_rdy(s);
      @(posedge clk); #1;
      cyc++;
      if (rb && k < 3) begin
        acc.push_back(cyc);
        k++;
        if (k < 3) begin
          req_size = bs[k]; req_uns = bu[k]; req_addr = 32'(ba[k]);
        end else begin
          set_valid(s, 1'b0);
        end
      end
      if (o_rv(s)) begin
        rcyc.push_back(cyc);
        rdat.push_back(o_rd(s));
      end
      n_vec++; if (o_busy(s) !== !o_rdy(s)) begin n_err++; $display("FAIL b2b_busy dut%0d cyc%0d busy=%b ready=%b", s, cyc, o_busy(s), o_rdy(s)); end
    end
    set_valid(s, 1'b0);
    n_vec++;
    if (acc.size() != 3 || rcyc.size() != 3) begin
      n_err++; $display("FAIL b2b_count dut%0d got acc=%0d rsp=%0d exp 3/3", s, acc.size(), rcyc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (i > 0) begin
          n_vec++; if (acc[i] - acc[i-1] !== le + 2) begin n_err++; $display("FAIL b2b_spacing dut%0d got=%0d exp=%0d", s, acc[i] - acc[i-1], le + 2); end
        end
        n_vec++; if (rcyc[i] !== acc[i] + le) begin n_err++; $display("FAIL b2b_rsp_time dut%0d #%0d got=%0d exp=%0d", s, i, rcyc[i], acc[i] + le); end
        n_vec++; if (rdat[i] !== bexp[i]) begin n_err++; $display("FAIL b2b_rdata dut%0d #%0d got=%h exp=%h", s, i, rdat[i], bexp[i]); end
      end
    end
    @(posedge clk); #1;
    n_vec++; if (o_rv(s) !== 1'b0 || o_rdy(s) !== 1'b1) begin n_err++; $display("FAIL b2b_end dut%0d valid=%b ready=%b exp 0/1", s, o_rv(s), o_rdy(s)); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; v2 = 1'b0; v0 = 1'b0;
    req_we = 1'b0; req_size = 2'd0; req_uns = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    test_fill();
    test_reset_abort();
    test_store_timing();
    test_errors();
    test_random();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
